// File: rtl/systolic_feed_ctrl.sv
// Sequencer for one systolic-array pass: clear accumulators, stream K operand
// reads, skew the edge valids across the rows, wait for the drain, pulse done.
module systolic_feed_ctrl #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int A_W    = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    // start_i is a single-cycle request with no ready: it is taken only when
    // the FSM is IDLE and dropped otherwise; k_len_i is sampled on that edge.
    input  logic           start_i,
    input  logic [K_W-1:0] k_len_i,
    output logic           busy_o,
    output logic           clr_acc_o,
    output logic           rd_en_o,
    output logic [A_W-1:0] rd_addr_o,
    output logic [N-1:0]   row_valid_o,
    output logic           done_o,
    output logic [2:0]     dbg_state_o
);

    localparam int DRAIN_LEN = 2 * N - 1 + RD_LAT;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN);
    localparam int CNT_W     = (K_W > DRAIN_W) ? K_W : DRAIN_W;
    localparam int SR_LEN    = RD_LAT + N - 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   feed_last;

    logic               busy_q, clr_acc_q, rd_en_q, done_q;
    logic [A_W-1:0]     rd_addr_q;
    logic [SR_LEN-1:0]  sr_q;

    // k_q is never zero outside IDLE, so k-1 cannot underflow.
    assign feed_last = CNT_W'(k_q) - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (k_len_i != '0) begin
                        k_d     = k_len_i;
                        state_d = CLEAR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are the registered decode of the state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_o_reset: begin
                busy_q    <= 1'b0;
                clr_acc_q <= 1'b0;
                rd_en_q   <= 1'b0;
                done_q    <= 1'b0;
                rd_addr_q <= '0;
                sr_q      <= '0;
            end
        end else begin
            busy_q    <= (state_q != IDLE);
            clr_acc_q <= (state_q == CLEAR);
            rd_en_q   <= (state_q == FEED);
            done_q    <= (state_q == DONE);
            if (state_q == FEED) begin
                rd_addr_q <= A_W'(cnt_q);
            end
            sr_q <= {sr_q[SR_LEN-2:0], rd_en_q};
        end
    end

    assign busy_o      = busy_q;
    assign clr_acc_o   = clr_acc_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign done_o      = done_q;
    // sr_q[j] is rd_en delayed j+1 cycles; row i needs a delay of RD_LAT+i.
    assign row_valid_o = sr_q[SR_LEN-1:RD_LAT-1];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl: a hand-computed nominal-pass table plus
// sequences for zero length, abort by reset, maximum length and back-to-back passes.
module tb_systolic_feed_ctrl;

    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int A_W    = 8;
    localparam int RD_LAT = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K_W-1:0] k_len;
    logic           busy, clr_acc, rd_en, done;
    logic [A_W-1:0] rd_addr;
    logic [N-1:0]   row_valid;
    logic [2:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [A_W-1:0] exp_q[$];

    typedef struct {
        logic           start;
        logic [K_W-1:0] k_len;
        logic           clr;
        logic           rd;
        logic [A_W-1:0] addr;
        logic [N-1:0]   rv;
        logic           busy;
        logic           done;
    } vec_t;

    vec_t tbl[15];

    systolic_feed_ctrl #(.N(N), .K_W(K_W), .A_W(A_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .k_len_i    (k_len),
        .busy_o     (busy),
        .clr_acc_o  (clr_acc),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .row_valid_o(row_valid),
        .done_o     (done),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [K_W-1:0] kl, input logic c,
                                input logic r, input logic [A_W-1:0] a, input logic [N-1:0] v,
                                input logic b, input logic d);
        vec_t t;
        t.start = st; t.k_len = kl; t.clr = c; t.rd = r;
        t.addr = a; t.rv = v; t.busy = b; t.done = d;
        return t;
    endfunction

    // Expected {clr_acc, rd_en, row_valid, busy, done} in cycle c of a pass of length k.
    function automatic logic [7:0] model_flags(input int c, input int k);
        logic clr, rd, bsy, dn;
        logic [N-1:0] rv;
        int last;
        rv = '0;
        if (k == 0) begin
            clr = 1'b0;
            rd  = 1'b0;
            bsy = (c == 1);
            dn  = (c == 1);
        end else begin
            last = k + 2 * N + RD_LAT + 1;
            clr  = (c == 1);
            rd   = (c >= 2) && (c <= k + 1);
            for (int i = 0; i < N; i++) begin
                rv[i] = (c >= 2 + RD_LAT + i) && (c <= k + 1 + RD_LAT + i);
            end
            bsy = (c >= 1) && (c <= last);
            dn  = (c == last);
        end
        return {clr, rd, rv, bsy, dn};
    endfunction

    task automatic check_cycle(input int c, input int k, input string tag);
        logic [A_W-1:0] a;
        check($sformatf("%s_c%0d", tag, c), 32'({clr_acc, rd_en, row_valid, busy, done}),
              32'(model_flags(c, k)));
        if (rd_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_addr_c%0d: got read at %h expected no read", tag, c, rd_addr);
            end else begin
                a = exp_q.pop_front();
                check($sformatf("%s_addr_c%0d", tag, c), 32'(rd_addr), 32'(a));
            end
        end
    endtask

    task automatic push_addrs(input int k);
        for (int a = 0; a < k; a++) exp_q.push_back(A_W'(a));
    endtask

    task automatic run_pass(input int k, input string tag);
        int last;
        last  = k + 2 * N + RD_LAT + 1;
        start = 1'b1;
        k_len = K_W'(k);
        push_addrs(k);
        tick();
        start = 1'b0;
        check_cycle(0, k, tag);
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            check_cycle(c, k, tag);
        end
        check($sformatf("%s_reads_left", tag), 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        // Nominal pass k=3: stray starts in cycles 4 and 13 and a k_len change
        // mid-pass must leave the pass untouched.
        tbl[0]  = mk(1, 3, 0, 0, 0, 4'h0, 0, 0);
        tbl[1]  = mk(0, 3, 1, 0, 0, 4'h0, 1, 0);
        tbl[2]  = mk(0, 3, 0, 1, 0, 4'h0, 1, 0);
        tbl[3]  = mk(0, 3, 0, 1, 1, 4'h1, 1, 0);
        tbl[4]  = mk(1, 9, 0, 1, 2, 4'h3, 1, 0);
        tbl[5]  = mk(0, 9, 0, 0, 2, 4'h7, 1, 0);
        tbl[6]  = mk(0, 9, 0, 0, 2, 4'he, 1, 0);
        tbl[7]  = mk(0, 9, 0, 0, 2, 4'hc, 1, 0);
        tbl[8]  = mk(0, 9, 0, 0, 2, 4'h8, 1, 0);
        tbl[9]  = mk(0, 9, 0, 0, 2, 4'h0, 1, 0);
        tbl[10] = mk(0, 9, 0, 0, 2, 4'h0, 1, 0);
        tbl[11] = mk(0, 9, 0, 0, 2, 4'h0, 1, 0);
        tbl[12] = mk(0, 9, 0, 0, 2, 4'h0, 1, 0);
        tbl[13] = mk(1, 0, 0, 0, 2, 4'h0, 1, 1);
        tbl[14] = mk(0, 3, 0, 0, 2, 4'h0, 0, 0);

        rst   = 1'b1;
        start = 1'b0;
        k_len = '0;
        repeat (3) tick();
        check("reset_outputs", 32'({clr_acc, rd_en, rd_addr, row_valid, busy, done}), 32'(0));
        check("reset_state", 32'(dbg_state), 32'(0));
        rst = 1'b0;
        tick();
        check("idle_outputs", 32'({clr_acc, rd_en, rd_addr, row_valid, busy, done}), 32'(0));

        for (int c = 0; c < 15; c++) begin
            start = tbl[c].start;
            k_len = tbl[c].k_len;
            tick();
            check($sformatf("nominal_c%0d", c),
                  32'({clr_acc, rd_en, rd_addr, row_valid, busy, done}),
                  32'({tbl[c].clr, tbl[c].rd, tbl[c].addr, tbl[c].rv, tbl[c].busy, tbl[c].done}));
        end
        start = 1'b0;

        // Zero-length pass: done immediately, no clear, no reads, address held.
        start = 1'b1;
        k_len = '0;
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            check($sformatf("k0_c%0d", c), 32'({clr_acc, rd_en, row_valid, busy, done}),
                  32'(model_flags(c, 0)));
            check($sformatf("k0_addr_c%0d", c), 32'(rd_addr), 32'(2));
        end

        // Abort mid-FEED with k=10: reset during cycle 5, quiet from cycle 6.
        start = 1'b1;
        k_len = 8'd10;
        push_addrs(10);
        tick();
        start = 1'b0;
        check_cycle(0, 10, "abort");
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_cycle(c, 10, "abort");
        end
        rst = 1'b1;
        tick();
        check("abort_c6_outputs", 32'({clr_acc, rd_en, rd_addr, row_valid, busy, done}), 32'(0));
        check("abort_c6_state", 32'(dbg_state), 32'(0));
        rst = 1'b0;
        exp_q.delete();
        for (int c = 7; c < 27; c++) begin
            tick();
            check($sformatf("abort_quiet_c%0d", c),
                  32'({clr_acc, rd_en, row_valid, busy, done}), 32'(0));
        end
        run_pass(2, "post_abort");

        // Longest pass: 255 reads, address must not wrap.
        run_pass(255, "kmax");

        // start held high with k=2: a new pass every 13 cycles.
        start = 1'b1;
        k_len = 8'd2;
        push_addrs(2);
        tick();
        for (int c = 0; c < 39; c++) begin
            if (c > 0) tick();
            if (c > 0 && (c % 13) == 0) push_addrs(2);
            check_cycle(c % 13, 2, "b2b");
        end
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("b2b_tail_c%0d", c),
                  32'({clr_acc, rd_en, row_valid, busy, done}), 32'(0));
        end
        check("b2b_reads_left", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
